// File: rtl/bin_to_bcd_4d.sv
// Sequential shift-and-add-3 binary to packed 4-digit BCD converter, one bit per clock.
// The result register only updates on the DONE cycle so downstream display never sees scratch values.
module bin_to_bcd_4d #(
  parameter int W    = 14,
  parameter int MAXV = 9999
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic [15:0]  bcd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          CW     = $clog2(W);
  localparam logic [W-1:0] MAXV_W = W'(MAXV);

  state_t          state_r;
  logic [W-1:0]    binreg_r;
  logic [15:0]     scratch_r;
  logic [CW-1:0]   cnt_r;
  logic            ovf_lat_r;

  logic            over_s;
  logic [W-1:0]    clamped_s;
  logic [15:0]     adj_s;

  // Add 3 to each nibble >= 5; nibbles are handled independently so no carry crosses digits.
  function automatic logic [15:0] add3(input logic [15:0] s);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Zero-extended compare keeps the clamp correct for every legal W.
  assign over_s    = ({{(32-W){1'b0}}, bin} > 32'(MAXV));
  assign clamped_s = over_s ? MAXV_W : bin;
  assign adj_s     = add3(scratch_r);

  // Conversion FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      binreg_r  <= '0;
      scratch_r <= 16'h0000;
      cnt_r     <= '0;
      ovf_lat_r <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      bcd       <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            binreg_r  <= clamped_s;
            ovf_lat_r <= over_s;
            scratch_r <= 16'h0000;
            cnt_r     <= CW'(W-1);
            busy      <= 1'b1;
            state_r   <= SHIFT;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          done      <= 1'b0;
          scratch_r <= {adj_s[14:0], binreg_r[W-1]};
          binreg_r  <= {binreg_r[W-2:0], 1'b0};
          cnt_r     <= cnt_r - CW'(1);
          if (cnt_r == CW'(0)) begin
            busy    <= 1'b0;
            state_r <= DONE;
          end else begin
            busy    <= 1'b1;
            state_r <= SHIFT;
          end
        end
        DONE: begin
          bcd  <= scratch_r;
          ovf  <= ovf_lat_r;
          done <= 1'b1;
          // A start seen here is accepted immediately, giving back-to-back throughput.
          if (start) begin
            binreg_r  <= clamped_s;
            ovf_lat_r <= over_s;
            scratch_r <= 16'h0000;
            cnt_r     <= CW'(W-1);
            busy      <= 1'b1;
            state_r   <= SHIFT;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_4d.sv
// Randomized self-checking bench for bin_to_bcd_4d against a decimal-arithmetic reference model.
module tb_bin_to_bcd_4d;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] bcd;

  int          n_checks;
  int          n_fail;
  logic [15:0] last_bcd;
  logic        last_ovf;

  bin_to_bcd_4d #(.W(14), .MAXV(9999)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: clamp, then split into decimal digits.
  function automatic logic [15:0] model_bcd(input int v);
    int m;
    m = (v > 9999) ? 9999 : v;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic run(input int v, input bit toggle, input bit spam);
    int k;
    int busy_n;
    logic [15:0] exp;
    @(negedge clk);
    bin   = 14'(v);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    k      = 0;
    busy_n = 0;
    while (done !== 1'b1 && k < 40) begin
      if (busy === 1'b1) busy_n++;
      check("hold_bcd", bcd, last_bcd);
      check("hold_ovf", ovf, last_ovf);
      if (toggle) bin = 14'($urandom_range(0, 16383));
      if (spam) begin
        bin   = 14'd42;
        start = (k >= 2 && k <= 11 && (k % 3) == 2);
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    exp   = model_bcd(v);
    check("latency", k, 15);
    check("busy_cycles", busy_n, 14);
    check("bcd", bcd, exp);
    check("ovf", ovf, (v > 9999));
    check("busy_at_done", busy, 1'b0);
    last_bcd = exp;
    last_ovf = (v > 9999);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_bcd = 16'h0000;
    last_ovf = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    bin      = 14'd0;
    #23;
    check("rst_bcd", bcd, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 1'b0, 1'b0);
    run(1234, 1'b1, 1'b0);
    run(9999, 1'b0, 1'b0);
    run(12000, 1'b0, 1'b0);
    run(5, 1'b0, 1'b0);
    run(7777, 1'b0, 1'b1);

    // Start held high through DONE: second conversion begins with no idle cycle.
    begin
      int k;
      @(negedge clk);
      bin   = 14'd300;
      start = 1'b1;
      k     = 0;
      @(negedge clk);
      while (done !== 1'b1 && k < 40) begin
        if (k == 5) bin = 14'd600;
        @(negedge clk);
        k++;
      end
      check("b2b_latency1", k, 15);
      check("b2b_bcd1", bcd, 16'h0300);
      check("b2b_busy", busy, 1'b1);
      start = 1'b0;
      k     = 0;
      @(negedge clk);
      while (done !== 1'b1 && k < 40) begin
        check("b2b_hold", bcd, 16'h0300);
        @(negedge clk);
        k++;
      end
      check("b2b_latency2", k, 14);
      check("b2b_bcd2", bcd, 16'h0600);
      last_bcd = 16'h0600;
      last_ovf = 1'b0;
      @(negedge clk);
    end

    // Reset partway through a conversion aborts without a done pulse.
    run(12000, 1'b0, 1'b0);
    @(negedge clk);
    bin   = 14'd5678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_bcd", bcd, 16'h0000);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_ovf", ovf, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    rst_n    = 1'b1;
    last_bcd = 16'h0000;
    last_ovf = 1'b0;
    run(5678, 1'b0, 1'b0);

    run(10000, 1'b0, 1'b0);
    run(16383, 1'b1, 1'b0);
    run(9998, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      run(int'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
